// File: rtl/udp_line_packer_if.sv
// ---------------------------------------------------------------------------
// udp_line_packer_if
//   Byte stream from the line packer to the UDP transmit path.
//   The master presents bytes. A byte moves when tx_valid and tx_ready are
//   both high in the same cycle.
//
//   tx_valid  master -> slave  tx_data/tx_first/tx_last are valid
//   tx_ready  slave  -> master downstream can take a byte this cycle
//   tx_data   master -> slave  payload byte
//   tx_first  master -> slave  high on the first header byte of a packet
//   tx_last   master -> slave  high on the final pixel low byte of a packet
// ---------------------------------------------------------------------------
interface udp_line_packer_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_first;
  logic       tx_last;

  modport master (
    output tx_valid,
    output tx_data,
    output tx_first,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  tx_first,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/udp_line_packer.sv
// ---------------------------------------------------------------------------
// udp_line_packer
//   Reads one camera line from the line swap buffer and sends it as one UDP
//   payload byte stream in the rclk domain. Each payload is a 6-byte header
//   followed by H_ACT RGB565 pixels, high byte first.
//   While tx_ready stays high, pixels are fetched one pixel ahead, so pixel
//   bytes leave at one byte per cycle.
//
//   rclk        in   clock (RGMII tx clock)
//   rstn        in   asynchronous active-low reset
//   en          in   enable; only looked at while idle
//   aquire      in   a full line is ready upstream
//   read_en     out  one-cycle fetch pulse; cam_data is valid the next cycle
//   cam_data    in   pixel data (RGB565)
//   cam_row     in   row of the ready line; valid while aquire=1
//   cam_id      in   camera id; valid while aquire=1
//   tx          mst  byte stream (tx_valid/tx_ready/tx_data/tx_first/tx_last)
//   udp_len     out  payload length 6 + 2*H_ACT (registered constant)
//   busy        out  high whenever not idle
//   lines_sent  out  count of completed lines; wraps to 0
// ---------------------------------------------------------------------------
module udp_line_packer #(
  parameter int H_ACT   = 1280,
  parameter int GAP_CYC = 2
) (
  input  logic                    rclk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    aquire,
  output logic                    read_en,
  input  logic [15:0]             cam_data,
  input  logic [10:0]             cam_row,
  input  logic [4:0]              cam_id,
  udp_line_packer_if.master       tx,
  output logic [15:0]             udp_len,
  output logic                    busy,
  output logic [31:0]             lines_sent
);

  localparam int CW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [CW-1:0] LAST_PIX = CW'(H_ACT - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_CYC - 1);
  localparam logic [15:0]   H_ACT16  = 16'(H_ACT);
  localparam logic [15:0]   UDP_LEN  = 16'(6 + 2 * H_ACT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PIX_HI,
    S_PIX_LO,
    S_GAP
  } state_t;

  state_t          state_q,   state_d;
  logic [4:0]      id_q,      id_d;
  logic [10:0]     row_q,     row_d;
  logic [2:0]      hdr_idx_q, hdr_idx_d;
  logic [CW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [15:0]     pix_cur_q, pix_cur_d;   // pixel being sent
  logic [15:0]     pix_nxt_q, pix_nxt_d;   // fetched pixel waiting for pix_cur
  logic            nxt_vld_q, nxt_vld_d;
  logic            cur_vld_q, cur_vld_d;
  logic            cap_q,     cap_d;       // cam_data holds a fetched pixel this cycle
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]     lines_q,   lines_d;
  logic [15:0]     udp_len_q, udp_len_d;

  logic [7:0]      hdr_byte;
  logic            load_cur;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    id_d      = id_q;
    row_d     = row_q;
    hdr_idx_d = hdr_idx_q;
    pix_cnt_d = pix_cnt_q;
    pix_cur_d = pix_cur_q;
    pix_nxt_d = pix_nxt_q;
    nxt_vld_d = nxt_vld_q;
    cur_vld_d = cur_vld_q;
    gap_cnt_d = gap_cnt_q;
    lines_d   = lines_q;
    udp_len_d = UDP_LEN;
    load_cur  = 1'b0;

    read_en     = 1'b0;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    tx.tx_first = 1'b0;
    tx.tx_last  = 1'b0;

    case (hdr_idx_q)
      3'd0:    hdr_byte = 8'hA5;
      3'd1:    hdr_byte = {3'b000, id_q};
      3'd2:    hdr_byte = {5'b00000, row_q[10:8]};
      3'd3:    hdr_byte = row_q[7:0];
      3'd4:    hdr_byte = H_ACT16[15:8];
      3'd5:    hdr_byte = H_ACT16[7:0];
      default: hdr_byte = 8'h00;
    endcase

    // A fetched pixel is parked in pix_nxt by default. A load into
    // pix_cur in the same cycle takes it straight from cam_data instead.
    if (cap_q) begin
      pix_nxt_d = cam_data;
      nxt_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (en && aquire) begin
          id_d      = cam_id;
          row_d     = cam_row;
          hdr_idx_d = 3'd0;
          pix_cnt_d = '0;
          cur_vld_d = 1'b0;
          state_d   = S_HDR;
        end
      end

      S_HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = hdr_byte;
        tx.tx_first = (hdr_idx_q == 3'd0);
        if (tx.tx_ready) begin
          if (hdr_idx_q == 3'd5) begin
            read_en = 1'b1;           // fetch pixel 0
            state_d = S_PIX_HI;
          end else begin
            hdr_idx_d = hdr_idx_q + 3'd1;
          end
        end
      end

      S_PIX_HI: begin
        // Only pixel 0 can reach here with pix_cur still empty. That
        // gives the single bubble after the header.
        tx.tx_valid = cur_vld_q;
        tx.tx_data  = pix_cur_q[15:8];
        if (!cur_vld_q) begin
          load_cur = cap_q || nxt_vld_q;
        end else if (tx.tx_ready) begin
          // Fetch the next pixel now. It arrives before the low byte is
          // accepted, so the following high byte needs no bubble.
          read_en = (pix_cnt_q != LAST_PIX);
          state_d = S_PIX_LO;
        end
      end

      S_PIX_LO: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = pix_cur_q[7:0];
        tx.tx_last  = (pix_cnt_q == LAST_PIX);
        if (tx.tx_ready) begin
          if (pix_cnt_q == LAST_PIX) begin
            lines_d   = lines_q + 32'd1;
            gap_cnt_d = '0;
            cur_vld_d = 1'b0;
            state_d   = S_GAP;
          end else begin
            pix_cnt_d = pix_cnt_q + CW'(1);
            load_cur  = 1'b1;
            state_d   = S_PIX_HI;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_END) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (load_cur) begin
      pix_cur_d = cap_q ? cam_data : pix_nxt_q;
      nxt_vld_d = 1'b0;
      cur_vld_d = 1'b1;
    end

    cap_d = read_en;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      row_q     <= '0;
      hdr_idx_q <= '0;
      pix_cnt_q <= '0;
      pix_cur_q <= '0;
      pix_nxt_q <= '0;
      nxt_vld_q <= 1'b0;
      cur_vld_q <= 1'b0;
      cap_q     <= 1'b0;
      gap_cnt_q <= '0;
      lines_q   <= '0;
      udp_len_q <= UDP_LEN;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      row_q     <= row_d;
      hdr_idx_q <= hdr_idx_d;
      pix_cnt_q <= pix_cnt_d;
      pix_cur_q <= pix_cur_d;
      pix_nxt_q <= pix_nxt_d;
      nxt_vld_q <= nxt_vld_d;
      cur_vld_q <= cur_vld_d;
      cap_q     <= cap_d;
      gap_cnt_q <= gap_cnt_d;
      lines_q   <= lines_d;
      udp_len_q <= udp_len_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign lines_sent = lines_q;
  assign udp_len    = udp_len_q;

endmodule

// File: tb/tb_udp_line_packer.sv
// ---------------------------------------------------------------------------
// tb_udp_line_packer
//   Self-checking bench for udp_line_packer with H_ACT=4 and GAP_CYC=2.
//   The reference model works at packet level. When a line starts, it
//   builds the full expected byte list from the latched id/row and that
//   line's pixels. Each cycle it then works out what tx_valid, tx_data,
//   tx_first, tx_last, read_en, busy and lines_sent must be.
//   Inputs change 1 time unit after the rising edge. Outputs are sampled
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_udp_line_packer;

  localparam int H_ACT   = 4;
  localparam int GAP_CYC = 2;
  localparam int PKT     = 6 + 2 * H_ACT;

  logic        rclk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        aquire = 1'b0;
  logic        read_en;
  logic [15:0] cam_data = '0;
  logic [10:0] cam_row = '0;
  logic [4:0]  cam_id = '0;
  logic [15:0] udp_len;
  logic        busy;
  logic [31:0] lines_sent;

  udp_line_packer_if tx_if ();

  udp_line_packer #(.H_ACT(H_ACT), .GAP_CYC(GAP_CYC)) dut (
    .rclk       (rclk),
    .rstn       (rstn),
    .en         (en),
    .aquire     (aquire),
    .read_en    (read_en),
    .cam_data   (cam_data),
    .cam_row    (cam_row),
    .cam_id     (cam_id),
    .tx         (tx_if),
    .udp_len    (udp_len),
    .busy       (busy),
    .lines_sent (lines_sent)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef enum {M_IDLE, M_LINE, M_GAP} mstate_t;
  mstate_t     m_state = M_IDLE;
  logic [7:0]  exp_q[$];
  int          m_sent = 0;
  int          m_lines = 0;
  int          gcnt = 0;
  int          rd_idx = 0;
  bit          bubble = 1'b0;
  logic [15:0] line_pix [H_ACT];
  bit          use_fixed = 1'b1;
  logic [15:0] fixed_pix [H_ACT] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  // camera responder and observation records
  bit          serve_now = 1'b0;
  logic [15:0] serve_val = '0;
  logic [7:0]  got[$];
  bit          last_seen = 1'b0;
  int          line_rd_cnt = 0;
  int          last_line_rd = 0;
  int          first_pix_cyc = 0;
  int          pix_span = 0;
  int          cyc = 0;
  int          win_rd = 0;
  int          win_valid = 0;
  int          last_end_cyc = -1000;
  int          last_gap = 0;
  int          rdy_mode = 0;

  // ---------------- compare process ----------------
  always @(negedge rclk) begin
    bit exp_valid;
    bit acc;
    bit exp_rd;
    int k;
    cyc++;
    if (!rstn) begin
      check("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
      check("rst_read_en", 32'(read_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_lines_sent", lines_sent, 32'd0);
      check("rst_udp_len", 32'(udp_len), 32'(PKT));
      m_state = M_IDLE;
      m_lines = 0;
      exp_q.delete();
      serve_now = 1'b0;
      bubble = 1'b0;
    end else begin
      exp_valid = (m_state == M_LINE) && !bubble;
      acc       = exp_valid && tx_if.tx_ready;
      k         = m_sent - 6;
      exp_rd    = acc && ((m_sent == 5) || (k >= 0 && (k % 2) == 0 && (k / 2) < H_ACT - 1));

      check("tx_valid", 32'(tx_if.tx_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("tx_data", 32'(tx_if.tx_data), 32'(exp_q[0]));
        check("tx_first", 32'(tx_if.tx_first), 32'(m_sent == 0));
        check("tx_last", 32'(tx_if.tx_last), 32'(exp_q.size() == 1));
      end
      check("read_en", 32'(read_en), 32'(exp_rd));
      check("busy", 32'(busy), 32'(m_state != M_IDLE));
      check("lines_sent", lines_sent, 32'(m_lines));
      check("udp_len", 32'(udp_len), 32'(PKT));

      if (read_en) win_rd++;
      if (tx_if.tx_valid) win_valid++;
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        got.push_back(tx_if.tx_data);
        if (tx_if.tx_last) last_seen = 1'b1;
      end

      // Serve the pixel for this fetch during the next cycle.
      serve_now = read_en;
      if (read_en) begin
        if (rd_idx < H_ACT) serve_val = line_pix[rd_idx];
        rd_idx++;
        line_rd_cnt++;
      end

      bubble = 1'b0;
      case (m_state)
        M_IDLE: begin
          if (en && aquire) begin
            for (int i = 0; i < H_ACT; i++)
              line_pix[i] = use_fixed ? fixed_pix[i] : 16'($urandom);
            exp_q.delete();
            exp_q.push_back(8'hA5);
            exp_q.push_back({3'b000, cam_id});
            exp_q.push_back({5'b00000, cam_row[10:8]});
            exp_q.push_back(cam_row[7:0]);
            exp_q.push_back(8'(H_ACT >> 8));
            exp_q.push_back(8'(H_ACT));
            for (int i = 0; i < H_ACT; i++) begin
              exp_q.push_back(line_pix[i][15:8]);
              exp_q.push_back(line_pix[i][7:0]);
            end
            m_sent      = 0;
            rd_idx      = 0;
            line_rd_cnt = 0;
            last_gap    = cyc - last_end_cyc;
            m_state     = M_LINE;
          end
        end
        M_LINE: begin
          if (acc) begin
            void'(exp_q.pop_front());
            if (m_sent == 6) first_pix_cyc = cyc;
            m_sent++;
            if (m_sent == 6) bubble = 1'b1;
            if (exp_q.size() == 0) begin
              m_lines++;
              pix_span     = cyc - first_pix_cyc + 1;
              last_line_rd = line_rd_cnt;
              last_end_cyc = cyc;
              gcnt         = 0;
              m_state      = M_GAP;
            end
          end
        end
        default: begin
          gcnt++;
          if (gcnt == GAP_CYC) m_state = M_IDLE;
        end
      endcase
    end
  end

  // ---------------- input pump: cam_data and tx_ready ----------------
  initial begin
    tx_if.tx_ready = 1'b0;
    forever begin
      @(posedge rclk);
      #1;
      cam_data = serve_now ? serve_val : 16'($urandom);
      case (rdy_mode)
        0:       tx_if.tx_ready = 1'b1;
        1:       tx_if.tx_ready = ~tx_if.tx_ready;
        default: tx_if.tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic wait_lines(input int target, input int budget, input string name);
    int n = 0;
    while (m_lines < target && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done"}, 32'(m_lines >= target), 32'd1);
  endtask

  logic [7:0] exp1 [PKT] = '{8'hA5, 8'h10, 8'h02, 8'hA5, 8'h00, 8'h04, 8'h12,
                             8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

  task automatic check_pkt(input string name, input int base);
    check({name, "_len"}, 32'(got.size() >= base + PKT), 32'd1);
    for (int i = 0; i < PKT; i++)
      if (base + i < got.size())
        check({name, "_byte"}, 32'(got[base + i]), 32'(exp1[i]));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    check("udp_len_after_reset", 32'(udp_len), 32'd14);
    check("lines_after_reset", lines_sent, 32'd0);

    // Reset after byte 8 of a line: no tx_last, nothing counted.
    cam_row = 11'h2A5;
    cam_id  = 5'b10000;
    en      = 1'b1;
    got.delete();
    last_seen = 1'b0;
    aquire = 1'b1;
    tick();
    aquire = 1'b0;
    n = 0;
    while (got.size() < 8 && n < 100) begin
      tick();
      n++;
    end
    #2;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    check("t5_bytes_before_reset", 32'(got.size()), 32'd8);
    check("t5_no_last", 32'(last_seen), 32'd0);
    check("t5_lines", lines_sent, 32'd0);

    // Full line with tx_ready=1, plus the continuous pixel burst.
    got.delete();
    last_seen = 1'b0;
    aquire = 1'b1;
    tick();
    aquire = 1'b0;
    wait_lines(1, 200, "t1");
    check_pkt("t1", 0);
    check("t1_first_byte", 32'(got[0]), 32'hA5);
    check("t1_last_seen", 32'(last_seen), 32'd1);
    check("t1_lines", lines_sent, 32'd1);
    check("t3_pixel_span", 32'(pix_span), 32'd8);
    check("t1_read_en_count", 32'(last_line_rd), 32'd4);

    // Same line with tx_ready toggling.
    repeat (4) tick();
    got.delete();
    rdy_mode = 1;
    aquire = 1'b1;
    tick();
    aquire = 1'b0;
    wait_lines(2, 400, "t2");
    check_pkt("t2", 0);
    check("t2_read_en_count", 32'(last_line_rd), 32'd4);
    check("t2_lines", lines_sent, 32'd2);

    // Two back-to-back lines, camera switched during the gap.
    repeat (4) tick();
    rdy_mode = 0;
    got.delete();
    cam_id = 5'b10000;
    aquire = 1'b1;
    wait_lines(3, 200, "t4a");
    cam_id = 5'b01000;
    wait_lines(4, 200, "t4b");
    aquire = 1'b0;
    check("t4_bytes", 32'(got.size()), 32'(2 * PKT));
    if (got.size() >= 2 * PKT) begin
      check("t4_pkt1_id", 32'(got[1]), 32'h10);
      check("t4_pkt2_hdr0", 32'(got[PKT]), 32'hA5);
      check("t4_pkt2_id", 32'(got[PKT + 1]), 32'h08);
    end
    check("t4_gap_cycles", 32'(last_gap), 32'd3);
    check("t4_lines", lines_sent, 32'd4);

    // en=0 holds the packer off; raising en starts a packet next cycle.
    repeat (5) tick();
    en = 1'b0;
    aquire = 1'b1;
    win_rd = 0;
    win_valid = 0;
    repeat (10) tick();
    check("t6_no_read_en", 32'(win_rd), 32'd0);
    check("t6_no_tx_valid", 32'(win_valid), 32'd0);
    en = 1'b1;
    tick();
    check("t6_valid_next_cycle", 32'(tx_if.tx_valid), 32'd1);
    check("t6_first", 32'(tx_if.tx_first), 32'd1);
    check("t6_data", 32'(tx_if.tx_data), 32'hA5);
    aquire = 1'b0;
    wait_lines(5, 200, "t6");

    // Randomized traffic against the model.
    rdy_mode  = 2;
    use_fixed = 1'b0;
    n = 0;
    while (m_lines < 30 && n < 5000) begin
      tick();
      aquire  = ($urandom_range(0, 1) == 1);
      en      = ($urandom_range(0, 9) != 0);
      cam_row = 11'($urandom);
      cam_id  = 5'($urandom);
      n++;
    end
    check("rand_lines_done", 32'(m_lines >= 30), 32'd1);
    aquire = 1'b0;
    en     = 1'b1;
    n = 0;
    while (m_state != M_IDLE && n < 500) begin
      tick();
      n++;
    end
    check("rand_drained", 32'(m_state == M_IDLE), 32'd1);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
